// File: rtl/axi_burst_read_engine.sv
// axi_burst_read_engine
//
// AXI4 read master that, after a start handshake, fetches data_size words
// starting at byte address axi_offset and stores them in a local single-port
// buffer starting at data_ptr. The transfer is split into INCR bursts of at
// most AXIMaxBurstLen beats, with one burst outstanding at a time. The write
// channels (AW/W/B) are tied off.
//
// Ports
//   clk, reset                      : clock and synchronous active-high reset
//   start_valid/start_ready         : command handshake (data_ptr, data_size, axi_offset)
//   done_valid/done_ready           : completion handshake, error valid with done_valid
//   buffer_addr/wdata/ce/we         : buffer write port, driven straight from the R handshake
//   ar*, r*                         : AXI4 read address / read data channels
//   aw*, w*, b*                     : AXI4 write channels, held idle
module axi_burst_read_engine #(
    parameter int BufferDataWidth = 32,
    parameter int BufferAddrWidth = 10,
    parameter int AXIAddrWidth    = 64,
    parameter int AXIDataWidth    = 32,
    parameter int AXIIDWidth      = 4,
    parameter int AXIMaxBurstLen  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_valid,
    output logic                        start_ready,
    output logic                        done_valid,
    input  logic                        done_ready,
    input  logic [BufferAddrWidth-1:0]  data_ptr,
    input  logic [BufferAddrWidth-1:0]  data_size,
    input  logic [AXIAddrWidth-1:0]     axi_offset,
    output logic                        error,
    output logic [BufferAddrWidth-1:0]  buffer_addr,
    output logic [BufferDataWidth-1:0]  buffer_wdata,
    output logic                        buffer_ce,
    output logic                        buffer_we,
    output logic [AXIAddrWidth-1:0]     araddr,
    output logic [AXIIDWidth-1:0]       arid,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [AXIDataWidth-1:0]     rdata,
    input  logic [AXIIDWidth-1:0]       rid,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [AXIAddrWidth-1:0]     awaddr,
    output logic [AXIIDWidth-1:0]       awid,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [AXIDataWidth-1:0]     wdata,
    output logic [AXIDataWidth/8-1:0]   wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [AXIIDWidth-1:0]       bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
);

    localparam int CNT_W   = BufferAddrWidth + 1;
    localparam int MAX_LOG = $clog2(AXIMaxBurstLen);
    localparam logic [BufferAddrWidth-1:0] MAX_MASK    = BufferAddrWidth'(AXIMaxBurstLen - 1);
    localparam logic [8:0]                 MAX_BEATS   = 9'(AXIMaxBurstLen);
    localparam logic [AXIAddrWidth-1:0]    BURST_BYTES = AXIAddrWidth'(AXIMaxBurstLen * (AXIDataWidth / 8));

    typedef enum logic [2:0] {
        IDLE, PREP, PRE_AR, AR, R, DONE
    } state_t;

    state_t                        state_reg, state_next;
    logic [BufferAddrWidth-1:0]    ptr_reg, size_reg;
    logic [AXIAddrWidth-1:0]       offset_reg, araddr_reg;
    logic [CNT_W-1:0]              num_batches_reg, batch_cnt_reg;
    logic [8:0]                    last_len_reg;
    logic [7:0]                    beat_cnt_reg, arlen_reg;
    logic                          error_reg;

    logic [BufferAddrWidth-1:0]    size_rem, size_quot;
    logic                          last_batch, beat_last, r_hs;

    assign size_rem   = size_reg & MAX_MASK;
    assign size_quot  = size_reg >> MAX_LOG;
    assign last_batch = (batch_cnt_reg + CNT_W'(1)) == num_batches_reg;
    assign beat_last  = beat_cnt_reg == arlen_reg;
    assign r_hs       = rvalid & rready;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_valid) state_next = PREP;
            PREP:    state_next = (size_reg == '0) ? DONE : PRE_AR;
            PRE_AR:  state_next = AR;
            AR:      if (arready) state_next = R;
            R:       if (rvalid && beat_last) state_next = last_batch ? DONE : PRE_AR;
            DONE:    if (done_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers, updated according to the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg         <= '0;
            size_reg        <= '0;
            offset_reg      <= '0;
            num_batches_reg <= '0;
            last_len_reg    <= '0;
            batch_cnt_reg   <= '0;
            beat_cnt_reg    <= '0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            error_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        ptr_reg    <= data_ptr;
                        size_reg   <= data_size;
                        offset_reg <= axi_offset;
                        error_reg  <= 1'b0;
                    end
                end
                PREP: begin
                    num_batches_reg <= CNT_W'(size_quot) + CNT_W'(size_rem != '0);
                    last_len_reg    <= (size_rem != '0) ? 9'(size_rem) : MAX_BEATS;
                    batch_cnt_reg   <= '0;
                end
                PRE_AR: begin
                    arlen_reg <= last_batch ? 8'(last_len_reg - 9'd1) : 8'(MAX_BEATS - 9'd1);
                    if (batch_cnt_reg == '0) begin
                        araddr_reg <= offset_reg;
                    end
                end
                AR: begin
                    // The increment only matters for the next burst, which
                    // reloads arlen but keeps this running address.
                    if (arready) begin
                        araddr_reg   <= araddr_reg + BURST_BYTES;
                        beat_cnt_reg <= '0;
                    end
                end
                R: begin
                    if (rvalid) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        // rlast is only checked, the burst ends on the beat count.
                        if ((rresp != 2'b00) || (rlast != beat_last)) begin
                            error_reg <= 1'b1;
                        end
                        if (beat_last && !last_batch) begin
                            batch_cnt_reg <= batch_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs
    assign start_ready = (state_reg == IDLE);
    assign done_valid  = (state_reg == DONE);
    assign error       = error_reg;

    // Buffer port follows the R handshake combinationally; the address wraps
    // modulo the buffer size.
    assign buffer_ce    = r_hs;
    assign buffer_we    = r_hs;
    assign buffer_wdata = rdata;
    assign buffer_addr  = ptr_reg
                        + BufferAddrWidth'(batch_cnt_reg << MAX_LOG)
                        + BufferAddrWidth'(beat_cnt_reg);

    // Read address / data channels
    assign araddr  = araddr_reg;
    assign arid    = '0;
    assign arlen   = arlen_reg;
    assign arsize  = 3'($clog2(AXIDataWidth / 8));
    assign arburst = 2'b01;
    assign arvalid = (state_reg == AR);
    assign rready  = (state_reg == R);

    // Write channels are unused by a read engine
    assign awaddr  = '0;
    assign awid    = '0;
    assign awlen   = '0;
    assign awsize  = '0;
    assign awburst = '0;
    assign awvalid = 1'b0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign wlast   = 1'b0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{rid, awready, wready, bid, bresp, bvalid};

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// Directed testbench for axi_burst_read_engine. A behavioural AXI read slave
// answers bursts with data derived from the byte address and logs every AR
// request, buffer write and the done event; the main sequence runs directed
// transfers and compares the logs against hand-computed values.
module tb_axi_burst_read_engine;

    logic        clk;
    logic        reset;
    logic        start_valid, start_ready, done_valid, done_ready;
    logic [9:0]  data_ptr, data_size;
    logic [63:0] axi_offset;
    logic        error;
    logic [9:0]  buffer_addr;
    logic [31:0] buffer_wdata;
    logic        buffer_ce, buffer_we;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [63:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_burst_read_engine dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .done_valid(done_valid), .done_ready(done_ready),
        .data_ptr(data_ptr), .data_size(data_size), .axi_offset(axi_offset),
        .error(error),
        .buffer_addr(buffer_addr), .buffer_wdata(buffer_wdata),
        .buffer_ce(buffer_ce), .buffer_we(buffer_we),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration
    int ar_delay, r_mode, err_beat, early_beat;

    // Logs filled by the slave/monitor
    int          cyc;
    logic [63:0] ar_addr_log [8];
    logic [7:0]  ar_len_log  [8];
    int          ar_rise_log [8];
    int          ar_hs_log   [8];
    int          ar_n;
    logic [9:0]  wr_addr_log [256];
    logic [31:0] wr_data_log [256];
    int          wr_n;
    int          start_cyc, done_cyc;
    bit          done_seen;
    logic        err_at_done;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " start_ready"}, 64'(start_ready), 64'd1);
        check({tag, " done_valid"}, 64'(done_valid), 64'd0);
        check({tag, " arvalid"}, 64'(arvalid), 64'd0);
        check({tag, " rready"}, 64'(rready), 64'd0);
        check({tag, " buffer_ce/we"}, 64'({buffer_ce, buffer_we}), 64'd0);
        check({tag, " error"}, 64'(error), 64'd0);
        check({tag, " araddr"}, araddr, 64'd0);
        check({tag, " arlen"}, 64'(arlen), 64'd0);
        check({tag, " buffer_addr"}, 64'(buffer_addr), 64'd0);
        check({tag, " buffer_wdata"}, 64'(buffer_wdata), 64'd0);
    endtask

    // AXI read slave + monitor. Observes at the falling edge, drives just
    // after the rising edge.
    initial begin : slave
        int          wait_cnt;
        bit          active;
        int          beat_idx, len;
        logic [63:0] base;
        bit          prev_arv;
        logic        n_arready, n_rvalid, n_rlast;
        logic [31:0] n_rdata;
        logic [1:0]  n_rresp;
        wait_cnt = 0; active = 0; beat_idx = 0; len = 0; base = '0; prev_arv = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                active = 0; wait_cnt = 0; prev_arv = 0;
            end else begin
                if (start_valid && start_ready) start_cyc = cyc;
                if (done_valid && !done_seen) begin
                    done_seen = 1; done_cyc = cyc; err_at_done = error;
                end
                if (arvalid && !prev_arv && ar_n < 8) ar_rise_log[ar_n] = cyc;
                prev_arv = arvalid;
                if (buffer_ce && buffer_we) begin
                    wr_addr_log[wr_n % 256] = buffer_addr;
                    wr_data_log[wr_n % 256] = buffer_wdata;
                    wr_n++;
                end
                if (rvalid && rready) begin
                    beat_idx++;
                    if (beat_idx > len) active = 0;
                end
                if (arvalid && arready) begin
                    if (ar_n < 8) begin
                        ar_addr_log[ar_n] = araddr;
                        ar_len_log[ar_n]  = arlen;
                        ar_hs_log[ar_n]   = cyc;
                    end
                    ar_n++;
                    active = 1; beat_idx = 0; len = int'(arlen); base = araddr;
                    wait_cnt = 0;
                end else if (arvalid) begin
                    wait_cnt++;
                end
            end
            n_arready = (ar_delay == 0) || (wait_cnt >= ar_delay);
            n_rvalid  = active && (r_mode == 0 || (cyc % 3) == 0);
            n_rdata   = n_rvalid ? word_at(base + 64'(4 * beat_idx)) : 32'd0;
            n_rresp   = (n_rvalid && beat_idx == err_beat) ? 2'b10 : 2'b00;
            n_rlast   = n_rvalid && ((early_beat >= 0) ? (beat_idx == early_beat) : (beat_idx == len));
            @(posedge clk);
            #1;
            arready = n_arready;
            rvalid  = n_rvalid;
            rdata   = n_rdata;
            rresp   = n_rresp;
            rlast   = n_rlast;
        end
    end

    task automatic start_xfer(input logic [9:0] ptr, input logic [9:0] size, input logic [63:0] off);
        int k;
        @(posedge clk);
        #1;
        ar_n = 0; wr_n = 0; done_seen = 0; start_cyc = -1; done_cyc = -1;
        data_ptr = ptr; data_size = size; axi_offset = off;
        start_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!start_ready && k < 50);
        check("start accepted", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input logic [9:0] ptr, input logic [9:0] size,
                               input logic [63:0] off, input logic exp_err);
        int k;
        logic [9:0] ea;
        k = 0;
        while (!done_seen && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done seen"}, 64'(done_seen), 64'd1);
        check({tag, " error at done"}, 64'(err_at_done), 64'(exp_err));
        check({tag, " write count"}, 64'(wr_n), 64'(size));
        for (int i = 0; i < int'(size) && i < 256; i++) begin
            ea = ptr + 10'(i);
            check($sformatf("%s wr%0d addr", tag, i), 64'(wr_addr_log[i]), 64'(ea));
            check($sformatf("%s wr%0d data", tag, i), 64'(wr_data_log[i]), 64'(word_at(off + 64'(4 * i))));
        end
        repeat (2) @(negedge clk);
        $display("xfer %s: ptr=0x%0h size=%0d offset=0x%0h bursts=%0d writes=%0d error=%0d",
                 tag, ptr, size, off, ar_n, wr_n, err_at_done);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int n_before;
        reset = 1'b1; start_valid = 1'b0; done_ready = 1'b1;
        data_ptr = '0; data_size = '0; axi_offset = '0;
        arready = 1'b1; rvalid = 1'b0; rdata = '0; rid = 4'h5; rresp = '0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        ar_delay = 0; r_mode = 0; err_beat = -1; early_beat = -1;
        cyc = 0; ar_n = 0; wr_n = 0; done_seen = 0; err_at_done = 0;
        start_cyc = -1; done_cyc = -1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        check("reset aw/w/b valid", 64'({awvalid, wvalid, bready}), 64'd0);
        check("reset aw/w tieoff", 64'(|{awaddr, awid, awlen, awsize, awburst, wdata, wstrb, wlast}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single short burst
        start_xfer(10'h010, 10'd5, 64'h1000);
        finish_xfer("size5", 10'h010, 10'd5, 64'h1000, 1'b0);
        check("size5 ar count", 64'(ar_n), 64'd1);
        check("size5 araddr", ar_addr_log[0], 64'h1000);
        check("size5 arlen", 64'(ar_len_log[0]), 64'd4);
        check("size5 start->arvalid", 64'(ar_rise_log[0] - start_cyc), 64'd3);
        check("size5 start->done", 64'(done_cyc - start_cyc), 64'd9);

        // Three bursts, last one partial
        start_xfer(10'h020, 10'd130, 64'h2000);
        finish_xfer("size130", 10'h020, 10'd130, 64'h2000, 1'b0);
        check("size130 ar count", 64'(ar_n), 64'd3);
        check("size130 ar0 addr", ar_addr_log[0], 64'h2000);
        check("size130 ar0 len", 64'(ar_len_log[0]), 64'd63);
        check("size130 ar1 addr", ar_addr_log[1], 64'h2100);
        check("size130 ar1 len", 64'(ar_len_log[1]), 64'd63);
        check("size130 ar2 addr", ar_addr_log[2], 64'h2200);
        check("size130 ar2 len", 64'(ar_len_log[2]), 64'd1);
        check("size130 ar0 hs->ar1", 64'(ar_rise_log[1] - ar_hs_log[0]), 64'd66);

        // Exactly one full burst, then an empty transfer
        start_xfer(10'h100, 10'd64, 64'h3000);
        finish_xfer("size64", 10'h100, 10'd64, 64'h3000, 1'b0);
        check("size64 ar count", 64'(ar_n), 64'd1);
        check("size64 araddr", ar_addr_log[0], 64'h3000);
        check("size64 arlen", 64'(ar_len_log[0]), 64'd63);
        start_xfer(10'h000, 10'd0, 64'h3800);
        finish_xfer("size0", 10'h000, 10'd0, 64'h3800, 1'b0);
        check("size0 ar count", 64'(ar_n), 64'd0);
        check("size0 start->done", 64'(done_cyc - start_cyc), 64'd2);

        // Stalled AR and sparse R beats
        ar_delay = 5; r_mode = 1;
        start_xfer(10'h200, 10'd70, 64'h5000);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!arvalid && k < 20);
        check("stall arvalid seen", 64'(arvalid), 64'd1);
        check("stall arsize", 64'(arsize), 64'd2);
        check("stall arid", 64'(arid), 64'd0);
        check("stall arburst", 64'(arburst), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall c%0d arvalid", i), 64'(arvalid), 64'd1);
            check($sformatf("stall c%0d araddr", i), araddr, 64'h5000);
            check($sformatf("stall c%0d arlen", i), 64'(arlen), 64'd63);
        end
        finish_xfer("stall", 10'h200, 10'd70, 64'h5000, 1'b0);
        check("stall ar count", 64'(ar_n), 64'd2);
        check("stall ar0 wait", 64'(ar_hs_log[0] - ar_rise_log[0]), 64'd5);
        check("stall ar1 addr", ar_addr_log[1], 64'h5100);
        check("stall ar1 len", 64'(ar_len_log[1]), 64'd5);
        ar_delay = 0; r_mode = 0;

        // Error response on beat 2, then early rlast on beat 1
        err_beat = 2;
        start_xfer(10'h300, 10'd4, 64'h6000);
        finish_xfer("rresp", 10'h300, 10'd4, 64'h6000, 1'b1);
        err_beat = -1; early_beat = 1;
        start_xfer(10'h304, 10'd4, 64'h6100);
        finish_xfer("rlast", 10'h304, 10'd4, 64'h6100, 1'b1);
        early_beat = -1;
        start_xfer(10'h308, 10'd3, 64'h6200);
        @(negedge clk);
        check("error cleared on start", 64'(error), 64'd0);
        finish_xfer("clean", 10'h308, 10'd3, 64'h6200, 1'b0);

        // Reset in the middle of a 64-beat burst
        start_xfer(10'h100, 10'd64, 64'h4000);
        k = 0;
        while (wr_n < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midreset 10 beats reached", 64'(wr_n >= 10), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_before = wr_n;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset no writes after reset", 64'(wr_n), 64'(n_before));
        check("midreset no done", 64'(done_seen), 64'd0);
        check("midreset no new AR", 64'(ar_n), 64'd1);
        start_xfer(10'h3FE, 10'd3, 64'h8000);
        finish_xfer("postreset", 10'h3FE, 10'd3, 64'h8000, 1'b0);
        check("postreset ar count", 64'(ar_n), 64'd1);
        check("postreset araddr", ar_addr_log[0], 64'h8000);
        check("postreset arlen", 64'(ar_len_log[0]), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
